// File: rtl/booth_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_ctrl_pkg
// Brief    : Shared types, datapath select codes and Booth decode helper for
//            the radix-2 Booth sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package booth_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_SUB  = 2'b10;

    // {Q0,Q-1}: 01 ends a run of ones (add M), 10 starts one (subtract M)
    function automatic logic [1:0] booth_sel(input logic [1:0] qo_q1);
        case (qo_q1)
            2'b01:   return SEL_ADD;
            2'b10:   return SEL_SUB;
            default: return SEL_PASS;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_ctrl
// Brief    : Sequencing FSM for the 16x16 radix-2 Booth multiplier datapath.
//            Optional build macro BOOTH_CTRL_ERRCHK_EN adds a step-count check.
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    input  logic                 abort,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic [WIDTH-1:0]     dp_multiplicand,
    output logic [WIDTH-1:0]     dp_multiplier,
    output logic                 dp_clear,
    output logic                 dp_mux_sel_Mul,
    output logic [1:0]           dp_mux_sel_Shift,
    input  logic [1:0]           dp_Qo_Q1,
    input  logic                 dp_count_comp,
    input  logic [2*WIDTH-1:0]   dp_product
);

    generate
        if (WIDTH != 16 || STEP_W != $clog2(WIDTH) + 1) begin : g_param_check
            $error("booth_seq_ctrl: WIDTH must be 16 and STEP_W must be $clog2(WIDTH)+1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_result;
    logic               r_res_valid;
    logic               w_exit;
    logic               w_accept;
    logic               w_capture;
    logic               w_release;

`ifdef BOOTH_CTRL_ERRCHK_EN
    logic [STEP_W-1:0]  r_step;
    logic               r_err;
    logic               w_last_step;

    assign w_last_step = (r_step == STEP_W'(WIDTH - 1));
    // Either a premature or a missing count_comp ends the run
    assign w_exit      = dp_count_comp | w_last_step;
    assign err         = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == LOAD)
                r_step <= '0;
            else if (r_state == RUN)
                r_step <= r_step + 1'b1;
            if (r_state == RUN && !abort && (dp_count_comp != w_last_step))
                r_err <= 1'b1;
        end
    end
`else
    assign w_exit = dp_count_comp;
    assign err    = 1'b0;
`endif

    assign w_accept  = (r_state == IDLE) & start_valid;
    assign w_capture = (r_state == RUN) & ~abort & w_exit;
    assign w_release = (r_state == DONE) & res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_mcand  <= multiplicand_in;
                r_mplier <= multiplier_in;
            end
            if (w_capture) begin
                r_result    <= dp_product;
                r_res_valid <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        start_ready      = 1'b0;
        busy             = 1'b0;
        dp_clear         = 1'b0;
        dp_mux_sel_Mul   = 1'b0;
        dp_mux_sel_Shift = SEL_PASS;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                dp_clear    = 1'b1;
                if (start_valid)
                    w_next_state = LOAD;
            end
            LOAD: begin
                busy         = 1'b1;
                w_next_state = abort ? IDLE : RUN;
            end
            RUN: begin
                busy             = 1'b1;
                dp_mux_sel_Mul   = 1'b1;
                dp_mux_sel_Shift = booth_sel(dp_Qo_Q1);
                // Abort has priority over a completing step
                if (abort)
                    w_next_state = IDLE;
                else if (w_exit)
                    w_next_state = DONE;
            end
            DONE: begin
                dp_clear = 1'b1;
                if (res_ready)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign res_valid       = r_res_valid;
    assign result          = r_result;
    assign dp_multiplicand = r_mcand;
    assign dp_multiplier   = r_mplier;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_ctrl
// Brief    : Scoreboard bench for booth_seq_ctrl with a behavioural Booth
//            datapath attached; honours BOOTH_CTRL_ERRCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] multiplicand_in = '0;
    logic [15:0] multiplier_in = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] result;
    logic        err;
    logic [15:0] dp_multiplicand;
    logic [15:0] dp_multiplier;
    logic        dp_clear;
    logic        dp_mux_sel_Mul;
    logic [1:0]  dp_mux_sel_Shift;
    logic [1:0]  dp_Qo_Q1;
    logic        dp_count_comp;
    logic [31:0] dp_product;

`ifdef BOOTH_CTRL_ERRCHK_EN
    localparam logic c_errchk = 1'b1;
`else
    localparam logic c_errchk = 1'b0;
`endif

    booth_seq_ctrl #(.WIDTH(16), .STEP_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_valid      (start_valid),
        .start_ready      (start_ready),
        .multiplicand_in  (multiplicand_in),
        .multiplier_in    (multiplier_in),
        .abort            (abort),
        .busy             (busy),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .err              (err),
        .dp_multiplicand  (dp_multiplicand),
        .dp_multiplier    (dp_multiplier),
        .dp_clear         (dp_clear),
        .dp_mux_sel_Mul   (dp_mux_sel_Mul),
        .dp_mux_sel_Shift (dp_mux_sel_Shift),
        .dp_Qo_Q1         (dp_Qo_Q1),
        .dp_count_comp    (dp_count_comp),
        .dp_product       (dp_product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: 17-bit accumulator so the most negative multiplicand is exact
    logic signed [16:0] dp_a;
    logic [15:0]        dp_q;
    logic               dp_qm1;
    logic [15:0]        dp_m;
    logic [4:0]         dp_cnt;
    logic               force_comp = 1'b0;
    logic [16:0]        w_sum;
    logic [33:0]        w_sh;

    always_comb begin
        case (dp_mux_sel_Shift)
            2'b01:   w_sum = dp_a + {dp_m[15], dp_m};
            2'b10:   w_sum = dp_a - {dp_m[15], dp_m};
            default: w_sum = dp_a;
        endcase
        w_sh = $signed({w_sum, dp_q, dp_qm1}) >>> 1;
    end

    assign dp_product    = w_sh[32:1];
    assign dp_Qo_Q1      = {dp_q[0], dp_qm1};
    assign dp_count_comp = (dp_cnt == 5'd16) || (force_comp && dp_cnt == 5'd11);

    always @(posedge clk) begin
        if (dp_clear) begin
            dp_a <= '0; dp_q <= '0; dp_qm1 <= 1'b0; dp_m <= '0; dp_cnt <= '0;
        end else if (!dp_mux_sel_Mul) begin
            dp_a <= '0; dp_q <= dp_multiplier; dp_qm1 <= 1'b0; dp_m <= dp_multiplicand; dp_cnt <= 5'd1;
        end else begin
            {dp_a, dp_q, dp_qm1} <= w_sh;
            dp_cnt <= dp_cnt + 5'd1;
        end
    end

    typedef struct {
        logic [31:0] res;
        bit          chk;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake
    initial begin : monitor
        logic        prev_v;
        logic [31:0] prev_r;
        exp_t        e;
        prev_v = 1'b0;
        prev_r = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 1'b0;
                continue;
            end
            if (res_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: res_valid=1 with nothing outstanding, result=%h", result);
                end else begin
                    chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
            end
            if (res_valid && prev_v)
                chk("result_hold", result, prev_r);
            if (res_valid && res_ready && sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk)
                    chk("product", result, e.res);
                chk("err", {31'b0, err}, {31'b0, exp_err});
            end
            prev_v = res_valid;
            prev_r = result;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push,
                         input bit chk_res, input int lat);
        exp_t e;
        logic signed [31:0] p;
        @(posedge clk); #1;
        start_valid     = 1'b1;
        multiplicand_in = a;
        multiplier_in   = b;
        @(negedge clk);
        if (!start_ready) begin
            checks++; errors++;
            $display("FAIL accept: start_ready=%0b required 1", start_ready);
        end else if (push) begin
            p = $signed(a) * $signed(b);
            e.res = p; e.chk = chk_res; e.acc = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_valid: res_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !start_ready || res_valid) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, outstanding=%0d", n, sb.size());
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int delay);
        res_ready = (delay == 0);
        issue(a, b, 1'b1, 1'b1, 17);
        if (delay > 0) begin
            wait_valid();
            repeat (delay) @(posedge clk);
            #1 res_ready = 1'b1;
        end
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] dir_a [8] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF};
        logic [15:0] dir_b [8] = '{16'h0005, 16'h7FFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h1234, 16'h7FFF, 16'hFFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", {31'b0, start_ready}, 32'd1);
        chk("rst_dp_clear",    {31'b0, dp_clear},    32'd1);
        chk("rst_busy",        {31'b0, busy},        32'd0);
        chk("rst_res_valid",   {31'b0, res_valid},   32'd0);
        chk("rst_result",      result,               32'd0);
        chk("rst_err",         {31'b0, err},         32'd0);
        chk("rst_dp_mcand",    {16'b0, dp_multiplicand}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(dir_a[i], dir_b[i], 0);

        // Result back-pressure: held stable, controller not ready for new work
        res_ready = 1'b0;
        issue(16'h0123, 16'hFF00, 1'b1, 1'b1, 17);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_start_ready", {31'b0, start_ready}, 32'd0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_start_ready", {31'b0, start_ready}, 32'd1);
        chk("bp_release_dp_clear",    {31'b0, dp_clear},    32'd1);
        wait_idle();

        // Abort at RUN step 8
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_start_ready", {31'b0, start_ready}, 32'd1);
        chk("abort_dp_clear",    {31'b0, dp_clear},    32'd1);
        chk("abort_busy",        {31'b0, busy},        32'd0);
        repeat (20) @(negedge clk);
        chk("abort_no_result", {31'b0, res_valid}, 32'd0);
        run_op(16'h0002, 16'h0003, 0);

        // Asynchronous reset in the middle of RUN
        issue(16'h4321, 16'h00AB, 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy",        {31'b0, busy},        32'd0);
        chk("arst_start_ready", {31'b0, start_ready}, 32'd1);
        chk("arst_dp_clear",    {31'b0, dp_clear},    32'd1);
        chk("arst_res_valid",   {31'b0, res_valid},   32'd0);
        chk("arst_result",      result,               32'd0);
        chk("arst_mul_sel",     {31'b0, dp_mux_sel_Mul}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        run_op(16'hFFF9, 16'h0031, 0);

        // Randomised operands and result back-pressure
        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);

        // Premature count_comp at step 10: early DONE, err only in the checked build
        force_comp = 1'b1;
        exp_err    = c_errchk;
        res_ready  = 1'b1;
        issue(16'h0BAD, 16'h1CE5, 1'b1, 1'b0, 12);
        wait_idle();
        force_comp = 1'b0;
        chk("err_sticky", {31'b0, err}, {31'b0, c_errchk});
        run_op(16'h0007, 16'hFFFE, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
